// File: rtl/seq_pkg.sv
// Shared encodings for the serial pattern generator and the sequence detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/serial-output bundle between a stimulus controller and seq_pattern_gen.
interface seq_pattern_gen_if #(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             x_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap,
    input  x_out, bit_valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap,
    output x_out, bit_valid, frame_start, busy, done
  );

endinterface

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; sout is the flopped MSB.
module seq_piso
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             clr,
  input  logic [PAT_W-1:0] din,
  output logic             sout
);

  logic [PAT_W-1:0] sreg;

  // Shifting in the idle level means the line drains to 0 after the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (clr) begin
      sreg <= {PAT_W{IDLE_LEVEL}};
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[PAT_W-2:0], IDLE_LEVEL};
    end
  end

  assign sout = sreg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial stimulus transmitter: sends a latched pattern MSB-first for N frames
// with an optional idle gap between frames.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.slave   bus
);

  localparam int unsigned     IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  seq_state_e       state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] frames_q, frames_n;
  logic [GAP_W-1:0] gcnt_q, gcnt_n;
  logic [PAT_W-1:0] sh_pattern;
  logic [GAP_W-1:0] sh_gap;
  logic             latch;
  logic             piso_load, piso_shift, piso_clr;
  logic [PAT_W-1:0] piso_din;
  logic             x_bit;
  logic             bit_valid_q, bit_valid_n;
  logic             frame_start_q, frame_start_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  // The start edge loads straight from the inputs so the MSB leaves one cycle later.
  assign piso_din = (state_q == IDLE) ? bus.pattern : sh_pattern;

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .clr   (piso_clr),
    .din   (piso_din),
    .sout  (x_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      frames_q      <= '0;
      gcnt_q        <= '0;
      sh_pattern    <= '0;
      sh_gap        <= '0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      frames_q      <= frames_n;
      gcnt_q        <= gcnt_n;
      bit_valid_q   <= bit_valid_n;
      frame_start_q <= frame_start_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
      if (latch) begin
        sh_pattern <= bus.pattern;
        sh_gap     <= bus.gap;
      end
    end
  end

  // Next state plus the output values for the cycle after this edge.
  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    frames_n      = frames_q;
    gcnt_n        = gcnt_q;
    latch         = 1'b0;
    piso_load     = 1'b0;
    piso_shift    = 1'b0;
    piso_clr      = 1'b0;
    bit_valid_n   = 1'b0;
    frame_start_n = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch  = 1'b1;
          busy_n = 1'b1;
          if (bus.repeat_cnt == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n       = SEND;
            idx_n         = IDX_TOP;
            frames_n      = bus.repeat_cnt;
            piso_load     = 1'b1;
            bit_valid_n   = 1'b1;
            frame_start_n = 1'b1;
          end
        end
      end

      SEND: begin
        busy_n = 1'b1;
        if (idx_q == '0) begin
          frames_n = frames_q - CNT_W'(1);
          if (frames_n == '0) begin
            state_n  = DONE;
            done_n   = 1'b1;
            piso_clr = 1'b1;
          end else if (sh_gap == '0) begin
            idx_n         = IDX_TOP;
            piso_load     = 1'b1;
            bit_valid_n   = 1'b1;
            frame_start_n = 1'b1;
          end else begin
            state_n  = GAP;
            gcnt_n   = sh_gap;
            piso_clr = 1'b1;
          end
        end else begin
          idx_n       = idx_q - IDX_W'(1);
          piso_shift  = 1'b1;
          bit_valid_n = 1'b1;
        end
      end

      GAP: begin
        busy_n = 1'b1;
        // Leaving on count 1 yields exactly sh_gap idle cycles.
        if (gcnt_q <= GAP_W'(1)) begin
          state_n       = SEND;
          gcnt_n        = '0;
          idx_n         = IDX_TOP;
          piso_load     = 1'b1;
          bit_valid_n   = 1'b1;
          frame_start_n = 1'b1;
        end else begin
          gcnt_n = gcnt_q - GAP_W'(1);
        end
      end

      DONE: begin
        state_n  = IDLE;
        piso_clr = 1'b1;
      end

      default: begin
        state_n  = IDLE;
        piso_clr = 1'b1;
      end
    endcase
  end

  assign bus.x_out       = x_bit;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
